// File: rtl/mips_if_prefetch_pkg.sv
// Shared constants for the MIPS prefetching fetch stage.
//   NOP          : instruction presented to ID when no valid word is available
//   DEF_RESET_PC : default first fetch address
//   PC_INC       : sequential fetch stride in bytes
package mips_if_prefetch_pkg;
    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          PC_INC       = 4;
endpackage

// File: rtl/mips_if_fifo.sv
// Synchronous FIFO used both as the prefetch buffer and as the in-flight tag queue.
// Ports:
//   clk, rst          : clock, async active-low reset
//   i_push / i_din    : write request and data (ignored when full unless popping too)
//   i_pop             : read request (ignored when empty)
//   i_flush           : empties the FIFO; wins over push and pop
//   o_dout            : head entry, combinational from storage
//   o_count           : occupancy, o_full / o_empty : status
module mips_if_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_dout,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push, w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/mips_if_prefetch.sv
// Instruction-fetch stage with prefetch buffer for the 5-stage MIPS pipeline.
// Owns the fetch PC, issues in-order requests to a variable-latency instruction
// memory, buffers returned words with their PC+4 and presents them to ID.
// Ports:
//   clk, rst                    : clock, async active-low reset
//   branch, pc_branch           : redirect request and target (low 2 bits ignored)
//   stall                       : ID cannot take an instruction this cycle
//   imem_req/addr, imem_gnt     : request channel (handshake = req & gnt)
//   imem_rvalid, imem_rdata     : in-order response channel
//   Instruction_F, PcPlus4_F    : head-of-buffer word and its PC+4 (NOP / 0 when empty)
//   valid_F                     : head valid
module mips_if_prefetch
    import mips_if_prefetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] Instruction_F,
    output logic [ADDR_W-1:0] PcPlus4_F,
    output logic              valid_F
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0]        r_pc;
    logic [AW:0]              r_drop;       // responses still owed to a flushed path
    logic [ADDR_W-1:0]        w_pc_inc;
    logic [AW:0]              w_in_flight, w_fifo_count;
    logic [AW+1:0]            w_credit_used;
    logic                     w_tag_empty, w_tag_full, w_fifo_empty, w_fifo_full;
    logic [ADDR_W-1:0]        w_tag_pc4;
    logic [DATA_W+ADDR_W-1:0] w_head;
    logic                     w_hs, w_rsp, w_push, w_pop;

    assign w_pc_inc      = r_pc + ADDR_W'(PC_INC);
    // Every outstanding request owns a buffer slot, so a response can always be stored.
    assign w_credit_used = {1'b0, w_in_flight} + {1'b0, w_fifo_count};
    assign imem_req      = rst && (w_credit_used < (AW+2)'(FIFO_DEPTH));
    assign imem_addr     = r_pc;
    assign w_hs          = imem_req && imem_gnt;
    // A response with nothing outstanding is illegal and is ignored.
    assign w_rsp         = imem_rvalid && !w_tag_empty;
    assign w_push        = w_rsp && (r_drop == '0) && !branch;
    assign valid_F       = !w_fifo_empty;
    assign w_pop         = valid_F && !stall && !branch;
    assign Instruction_F = valid_F ? w_head[ADDR_W +: DATA_W] : DATA_W'(NOP);
    assign PcPlus4_F     = valid_F ? w_head[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= RESET_PC;
            r_drop <= '0;
        end else if (branch) begin
            r_pc   <= {pc_branch[ADDR_W-1:2], 2'b00};
            // Everything still outstanding after this edge belongs to the old path.
            r_drop <= w_in_flight + (AW+1)'(w_hs) - (AW+1)'(w_rsp);
        end else begin
            if (w_hs)                   r_pc   <= w_pc_inc;
            if (w_rsp && r_drop != '0)  r_drop <= r_drop - (AW+1)'(1);
        end
    end

    // PC+4 of each in-flight request, popped as responses return in order.
    mips_if_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_hs),
        .i_din   (w_pc_inc),
        .i_pop   (w_rsp),
        .i_flush (1'b0),
        .o_dout  (w_tag_pc4),
        .o_count (w_in_flight),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    mips_if_fifo #(.W(DATA_W+ADDR_W), .DEPTH(FIFO_DEPTH)) u_pf_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({imem_rdata, w_tag_pc4}),
        .i_pop   (w_pop),
        .i_flush (branch),
        .o_dout  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifndef SYNTHESIS
    a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> !w_tag_empty);
    a_tag_no_ovf:   assert property (@(posedge clk) disable iff (!rst)
        w_hs |-> !w_tag_full);
    a_pf_no_ovf:    assert property (@(posedge clk) disable iff (!rst)
        w_push |-> (!w_fifo_full || w_pop));
`endif
endmodule

// File: tb/tb_mips_if_prefetch.sv
// Bench for mips_if_prefetch: a behavioural instruction memory (in-order, random
// grant and latency, data = address) feeds the DUT; the reference model tracks the
// address the fetch stage must request next and the PC+4 ID must receive next.
module tb_mips_if_prefetch;
    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch = 1'b0, stall = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, valid_F;
    logic [31:0] imem_addr, imem_rdata = '0, Instruction_F, PcPlus4_F;
    // second instance for the wrapping reset address
    logic        imem_req_w, gnt_w = 1'b0, rvalid_w = 1'b0, valid_F_w;
    logic [31:0] imem_addr_w, rdata_w = '0, Instruction_F_w, PcPlus4_F_w;

    int checks = 0, errors = 0;
    int cyc = 0, gnt_mode = 2, lat_lo = 1, lat_hi = 1, n_pop = 0, n_hs = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_fetch, exp_next, first_pc4;
    logic        exp_blank, last_valid, last_req;

    always #5 clk = ~clk;

    mips_if_prefetch dut (
        .clk(clk), .rst(rst), .branch(branch), .pc_branch(pc_branch), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instruction_F(Instruction_F), .PcPlus4_F(PcPlus4_F), .valid_F(valid_F));

    mips_if_prefetch #(.RESET_PC(RPC1)) dut_w (
        .clk(clk), .rst(rst), .branch(1'b0), .pc_branch(32'h0), .stall(1'b0),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(gnt_w),
        .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .Instruction_F(Instruction_F_w), .PcPlus4_F(PcPlus4_F_w), .valid_F(valid_F_w));

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        case (gnt_mode)
            0:       imem_gnt = ($urandom_range(0, 1) == 1);
            1:       imem_gnt = 1'b1;
            default: imem_gnt = 1'b0;
        endcase
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq_addr[0];
        end
        #1;
        last_valid = valid_F;
        last_req   = imem_req;
        if (exp_blank) begin
            checks++;
            if (valid_F !== 1'b0) begin
                errors++; $display("FAIL post_branch_valid: got %b expected 0", valid_F);
            end
        end
        exp_blank = 1'b0;
        if (!valid_F) begin
            checks++;
            if (Instruction_F !== 32'h0 || PcPlus4_F !== 32'h0) begin
                errors++;
                $display("FAIL idle_outputs: got %h/%h expected 0/0", Instruction_F, PcPlus4_F);
            end
        end
        if (imem_req) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
                errors++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_fetch);
            end
        end
        if (valid_F && !stall && !branch) begin
            checks++;
            if (PcPlus4_F !== exp_next || Instruction_F !== exp_next - 32'd4) begin
                errors++;
                $display("FAIL id_word: got %h/%h expected %h/%h",
                         PcPlus4_F, Instruction_F, exp_next, exp_next - 32'd4);
            end
            if (n_pop == 0) first_pc4 = PcPlus4_F;
            exp_next = exp_next + 32'd4;
            n_pop++;
        end
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
            exp_fetch = exp_fetch + 32'd4;
            n_hs++;
        end
        if (branch) begin
            exp_fetch = pc_branch & ~32'd3;
            exp_next  = exp_fetch + 32'd4;
            exp_blank = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; branch = 1'b0; pc_branch = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        gnt_w = 1'b0; rvalid_w = 1'b0; rdata_w = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq_addr.delete(); mq_due.delete();
        exp_fetch = RPC0; exp_next = RPC0 + 32'd4; exp_blank = 1'b0;
        n_pop = 0; n_hs = 0; cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_F); end
        checks++; if (Instruction_F !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", Instruction_F); end
        checks++; if (PcPlus4_F !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h expected 0", PcPlus4_F); end
        checks++; if (imem_req_w !== 1'b0) begin errors++; $display("FAIL rst_req_w: got %b expected 0", imem_req_w); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        gnt_mode = 1; lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            checks++;
            if (last_valid !== (k >= 2)) begin
                errors++; $display("FAIL first_valid c%0d: got %b expected %b", k, last_valid, k >= 2);
            end
        end
        checks++;
        if (n_pop != 10) begin errors++; $display("FAIL basic_throughput: got %0d expected 10", n_pop); end
    endtask

    task automatic test_stall();
        do_reset();
        gnt_mode = 1; lat_lo = 1; lat_hi = 1; stall = 1'b1;
        repeat (6) cycle();
        checks++;
        if (n_hs != 4) begin errors++; $display("FAIL stall_reqs: got %0d expected 4", n_hs); end
        checks++;
        if (last_req !== 1'b0) begin errors++; $display("FAIL stall_req_low: got %b expected 0", last_req); end
        #1;
        checks++;
        if (valid_F !== 1'b1 || PcPlus4_F !== 32'd4) begin
            errors++; $display("FAIL stall_head: got %b/%h expected 1/00000004", valid_F, PcPlus4_F);
        end
        stall = 1'b0;
        repeat (10) cycle();
        checks++;
        if (n_pop < 4) begin errors++; $display("FAIL stall_drain: got %0d expected >=4", n_pop); end
    endtask

    task automatic test_branch();
        do_reset();
        gnt_mode = 1; lat_lo = 5; lat_hi = 5;
        repeat (3) cycle();
        checks++;
        if (mq_addr.size() != 3) begin errors++; $display("FAIL br_inflight: got %0d expected 3", mq_addr.size()); end
        gnt_mode = 2; branch = 1'b1; pc_branch = 32'h0F0F_0F03;
        cycle();
        branch = 1'b0; gnt_mode = 1; n_pop = 0;
        for (int k = 0; k < 30 && n_pop == 0; k++) cycle();
        checks++;
        if (n_pop == 0 || first_pc4 !== 32'h0F0F_0F04) begin
            errors++; $display("FAIL br_target: got %h (pops %0d) expected 0f0f0f04", first_pc4, n_pop);
        end
    endtask

    task automatic test_random();
        do_reset();
        gnt_mode = 0; lat_lo = 1; lat_hi = 5;
        for (int k = 0; k < 40000 && n_pop < 1000; k++) begin
            stall     = ($urandom_range(0, 9) < 3);
            branch    = ($urandom_range(0, 39) == 0);
            pc_branch = $urandom;
            cycle();
        end
        stall = 1'b0; branch = 1'b0;
        checks++;
        if (n_pop < 1000) begin errors++; $display("FAIL random_timeout: got %0d expected 1000", n_pop); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a[4];
        logic [31:0] exp_p[3];
        logic [31:0] prev_addr;
        logic        prev_hs;
        int          na, np;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
        exp_p[0] = 32'hFFFF_FFFC; exp_p[1] = 32'h0; exp_p[2] = 32'h4;
        do_reset();
        prev_hs = 1'b0; prev_addr = '0; na = 0; np = 0;
        gnt_w = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rvalid_w = prev_hs;
            rdata_w  = prev_hs ? prev_addr : 32'h0;
            #1;
            if (valid_F_w) begin
                if (np < 3) begin
                    checks++;
                    if (PcPlus4_F_w !== exp_p[np] || Instruction_F_w !== exp_p[np] - 32'd4) begin
                        errors++;
                        $display("FAIL wrap_pc4 %0d: got %h/%h expected %h", np, PcPlus4_F_w, Instruction_F_w, exp_p[np]);
                    end
                end
                np++;
            end
            prev_hs   = imem_req_w && gnt_w;
            prev_addr = imem_addr_w;
            if (prev_hs) begin
                if (na < 4) begin
                    checks++;
                    if (imem_addr_w !== exp_a[na]) begin
                        errors++; $display("FAIL wrap_addr %0d: got %h expected %h", na, imem_addr_w, exp_a[na]);
                    end
                end
                na++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        gnt_w = 1'b0; rvalid_w = 1'b0;
        checks++;
        if (np < 3 || na < 4) begin errors++; $display("FAIL wrap_count: got %0d/%0d expected 3/4", np, na); end
    endtask

    task automatic test_midreset();
        do_reset();
        gnt_mode = 1; lat_lo = 2; lat_hi = 2; stall = 1'b1;
        repeat (3) cycle();
        #1;
        checks++;
        if (valid_F !== 1'b1 || mq_addr.size() != 2) begin
            errors++; $display("FAIL mid_pre: got %b/%0d expected 1/2", valid_F, mq_addr.size());
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || valid_F !== 1'b0 || Instruction_F !== 32'h0 || PcPlus4_F !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_out: got %b/%b/%h/%h expected 0/0/0/0", imem_req, valid_F, Instruction_F, PcPlus4_F);
        end
        @(negedge clk);
        do_reset();
        gnt_mode = 1; lat_lo = 1; lat_hi = 1;
        repeat (8) cycle();
        checks++;
        if (n_pop == 0 || first_pc4 !== 32'd4) begin
            errors++; $display("FAIL mid_restart: got %h (pops %0d) expected 00000004", first_pc4, n_pop);
        end
    endtask

    initial begin
        exp_fetch = RPC0; exp_next = RPC0 + 32'd4; exp_blank = 1'b0;
        first_pc4 = '0; last_valid = 1'b0; last_req = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_random();
        test_wrap();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
